instr_encoder: RTL

- Inverse of the datapath's immediate extractor: packs opcode, funct3, register indices and a 64-bit signed immediate into a 32-bit RV64 instruction word.
- Supports the I (loads, ALU-imm, JALR), S, SB, U (LUI) and UJ formats.
- Checks that the immediate is representable in the target format and reports an error code when it is not.
- Used by the self-test instruction generator to feed instruction memory.
- Valid/ready input and output, with a small output FIFO for backpressure.

---
 rtl/instr_encoder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: packs opcode, funct3, register indices and a signed 64-bit
// immediate into a 32-bit RV64 instruction word (I, S, SB, U, UJ formats).
// It flags immediates that the target format cannot represent and queues
// {error code, word} pairs in a small output FIFO.
module instr_encoder #(
  parameter int FIFO_DEPTH = 2,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           in_opcode,
  input  logic [2:0]           in_funct3,
  input  logic [4:0]           in_rd,
  input  logic [4:0]           in_rs1,
  input  logic [4:0]           in_rs2,
  input  logic [63:0]          in_imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic [1:0]           out_err_code,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_ALUI   = 7'd19;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_JAL    = 7'd111;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_ALIGN = 2'b10;
  localparam logic [1:0] ERR_OPC   = 2'b11;

  // Representability: the immediate fits an N-bit signed field when every
  // bit above the field's sign bit is a copy of it.
  logic w_fit12;
  logic w_fit13;
  logic w_fit21;
  logic w_fit32;
  assign w_fit12 = (in_imm[63:11] == {53{in_imm[11]}});
  assign w_fit13 = (in_imm[63:12] == {52{in_imm[12]}});
  assign w_fit21 = (in_imm[63:20] == {44{in_imm[20]}});
  assign w_fit32 = (in_imm[63:31] == {33{in_imm[31]}});

  logic [31:0] w_word;
  logic [1:0]  w_code;

  // Combinational packing and error classification of the current request.
  // The SB/UJ even-offset rule makes the 13/21-bit fit checks exact: the only
  // in-field values outside the legal range are odd and report misaligned.
  always_comb begin
    w_word = 32'h0000_0013;
    w_code = ERR_OK;
    case (in_opcode)
      OP_LOAD, OP_ALUI, OP_JALR: begin
        w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        if (!w_fit12) w_code = ERR_RANGE;
      end
      OP_STORE: begin
        w_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        if (!w_fit12) w_code = ERR_RANGE;
      end
      OP_BRANCH: begin
        w_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                  in_imm[4:1], in_imm[11], in_opcode};
        if (in_imm[0])     w_code = ERR_ALIGN;
        else if (!w_fit13) w_code = ERR_RANGE;
      end
      OP_LUI: begin
        // Nonzero low 12 bits cannot be expressed by LUI: treated as an
        // alignment fault (value not on a 4 KiB boundary).
        w_word = {in_imm[31:12], in_rd, in_opcode};
        if (in_imm[11:0] != 12'd0) w_code = ERR_ALIGN;
        else if (!w_fit32)         w_code = ERR_RANGE;
      end
      OP_JAL: begin
        w_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        if (in_imm[0])     w_code = ERR_ALIGN;
        else if (!w_fit21) w_code = ERR_RANGE;
      end
      default: begin
        w_word = 32'h0000_0013;
        w_code = ERR_OPC;
      end
    endcase
  end

  logic [33:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [ERR_CNT_W-1:0] r_err_count;

  logic w_push;
  logic w_pop;
  logic [33:0] w_head;

  assign in_ready  = (r_count < DEPTH_C);
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign w_head    = r_mem[r_rd_ptr];

  // An empty FIFO presents zeros so stale entries never leak out after reset.
  assign out_instr    = out_valid ? w_head[31:0]  : 32'd0;
  assign out_err_code = out_valid ? w_head[33:32] : 2'b00;
  assign err_count    = r_err_count;

  // FIFO storage; contents need no reset since visibility is gated by count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_code, w_word};
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Saturating count of accepted requests that carried an error code.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_count <= '0;
    end else if (w_push && (w_code != ERR_OK) && (r_err_count != '1)) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

endmodule
